// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, 1-cycle synchronous imem port,
// one-entry skid buffer for stalls, and the IF/ID pipeline register.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_fetch_stage #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = 8'h00,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic            jmp,
  input  logic [PC_W-1:0] pc_branch,
  input  logic [PC_W-1:0] pc_jmp,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]     perf_fetched,
  output logic [15:0]     perf_bubbles,
`endif
  output logic [31:0]     id_instr
);

  // FILL: nothing in flight; RUN: one read in flight; HOLD: one instruction parked
  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;

  logic            take_s;
  logic [PC_W-1:0] target_s;
  logic            issue_s;

  // Redirect decode: jump has priority over a taken BEQ
  always_comb begin
    take_s   = jmp | (branch & alu_zero);
    target_s = jmp ? pc_jmp : pc_branch;
    issue_s  = ~take_s & ~stall;
  end

  // The read strobe is combinational so data lands exactly one cycle later
  assign imem_en   = issue_s & rst_n;
  assign imem_addr = fetch_pc_q;

  // Next-state, PC and IF/ID update; a redirect overrides stall in every state
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    infl_pc_d    = infl_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;

    if (take_s) begin
      // Wrong-path instruction in ID is squashed; in-flight read and skid dropped
      state_d      = S_FILL;
      fetch_pc_d   = target_s;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = {PC_W{1'b0}};
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
    end else begin
      case (state_q)
        S_FILL: begin
          if (!stall) begin
            state_d    = S_RUN;
            id_valid_d = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end
        S_RUN: begin
          if (!stall) begin
            id_instr_d = imem_rdata;
            id_pc_d    = infl_pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            id_valid_d = 1'b1;
          end else begin
            // Memory data is only valid this cycle, so park it
            skid_instr_d = imem_rdata;
            skid_pc_d    = infl_pc_q;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            id_valid_d = 1'b1;
            state_d    = S_RUN;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d    = S_FILL;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end
      endcase

      if (issue_s) begin
        infl_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end else begin
        infl_pc_d = infl_pc_q;
      end
    end
  end

  // State, PC, skid and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      fetch_pc_q   <= RESET_PC;
      infl_pc_q    <= {PC_W{1'b0}};
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= {PC_W{1'b0}};
      id_valid_q   <= 1'b0;
      id_pc_q      <= {PC_W{1'b0}};
      id_instr_q   <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      infl_pc_q    <= infl_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

`ifdef IF_PERF_CNT_EN
  logic        perf_fetch_inc_s;
  logic        perf_bubble_inc_s;
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_bubbles_q, perf_bubbles_d;

  // Count valid IF/ID loads and unstalled bubble loads, saturating at all-ones
  always_comb begin
    perf_fetch_inc_s  = ~take_s & ~stall & (state_q != S_FILL);
    perf_bubble_inc_s = ~stall & (take_s | (state_q == S_FILL));
    perf_fetched_d    = perf_fetched_q;
    perf_bubbles_d    = perf_bubbles_q;
    if (perf_fetch_inc_s && (perf_fetched_q != 16'hFFFF)) begin
      perf_fetched_d = perf_fetched_q + 16'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (perf_bubble_inc_s && (perf_bubbles_q != 16'hFFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 16'd1;
    end else begin
      perf_bubbles_d = perf_bubbles_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 16'h0000;
      perf_bubbles_q <= 16'h0000;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: imem model returns 0x1000_0000+addr,
// a queue holds the expected order of fetched addresses for every IF/ID load.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        alu_zero;
  logic        jmp;
  logic [7:0]  pc_branch;
  logic [7:0]  pc_jmp;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [7:0]  id_pc;
  logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;
`endif

  int total;
  int bad;
  int pops;
  logic [7:0] exp_q[$];

  if_fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .jmp        (jmp),
    .pc_branch  (pc_branch),
    .pc_jmp     (pc_jmp),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles),
`endif
    .id_instr   (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory with 1-cycle latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + {24'h000000, imem_addr};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_run(input logic [7:0] start, input int n);
    logic [7:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 8'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every unstalled edge that leaves id_valid=1 is a new IF/ID load
  logic sb_stall;
  logic sb_rst;
  always @(posedge clk) begin
    logic [7:0] a;
    logic [7:0] n;
    sb_stall = stall;
    sb_rst   = rst_n;
    #1;
    if (!sb_rst) begin
      pops = 0;
    end else if (!sb_stall && id_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        a = exp_q.pop_front();
        n = a + 8'd1;
        pops++;
        check_eq("sb_instr", id_instr, 32'h1000_0000 + {24'h000000, a});
        check_eq("sb_pc", {24'h000000, id_pc}, {24'h000000, n});
      end
    end
  end

  initial begin
    total = 0; bad = 0; pops = 0;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; alu_zero = 1'b0; jmp = 1'b0;
    pc_branch = 8'h00; pc_jmp = 8'h00; imem_rdata = 32'h0;

    // Reset state
    step(); step();
    check_eq("rst_en", {31'd0, imem_en}, 32'd0);
    check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_instr", id_instr, 32'h0000_0000);
    check_eq("rst_pc", {24'd0, id_pc}, 32'd0);

    // Release and run free
    rst_n = 1'b1;
    push_run(8'h00, 64);
    #1;
    check_eq("rel_en", {31'd0, imem_en}, 32'd1);
    check_eq("rel_addr", {24'd0, imem_addr}, 32'h00);
    step();
    check_eq("edge1_valid", {31'd0, id_valid}, 32'd0);
    check_eq("edge1_addr", {24'd0, imem_addr}, 32'h01);
    step();
    check_eq("edge2_valid", {31'd0, id_valid}, 32'd1);
    check_eq("edge2_instr", id_instr, 32'h1000_0000);
    check_eq("edge2_pc", {24'd0, id_pc}, 32'h01);
    check_eq("edge2_addr", {24'd0, imem_addr}, 32'h02);
    for (int i = 3; i <= 6; i++) begin
      step();
      check_eq("run_addr", {24'd0, imem_addr}, i);
    end
    check_eq("pre_stall_instr", id_instr, 32'h1000_0004);

    // Stall 3 cycles with @05 in flight
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_en", {31'd0, imem_en}, 32'd0);
      step();
      check_eq("stall_hold", id_instr, 32'h1000_0004);
    end
    stall = 1'b0;
    step();
    check_eq("unstall_05", id_instr, 32'h1000_0005);
    step();
    check_eq("unstall_06", id_instr, 32'h1000_0006);

    // Taken branch to 0x40
    branch = 1'b1; alu_zero = 1'b1; pc_branch = 8'h40;
    exp_q.delete(); push_run(8'h40, 64);
    step();
    branch = 1'b0; alu_zero = 1'b0;
    check_eq("br_bub1", {31'd0, id_valid}, 32'd0);
    step();
    check_eq("br_bub2", {31'd0, id_valid}, 32'd0);
    step();
    check_eq("br_valid", {31'd0, id_valid}, 32'd1);
    check_eq("br_instr", id_instr, 32'h1000_0040);
    check_eq("br_pc", {24'd0, id_pc}, 32'h41);
    // Untaken BEQ
    branch = 1'b1; alu_zero = 1'b0; pc_branch = 8'h20;
    step();
    branch = 1'b0;
    check_eq("nt_instr", id_instr, 32'h1000_0041);
    check_eq("nt_pc", {24'd0, id_pc}, 32'h42);

    // Jump + taken branch together while in HOLD
    stall = 1'b1;
    step(); step();
    jmp = 1'b1; pc_jmp = 8'h80; branch = 1'b1; alu_zero = 1'b1; pc_branch = 8'h40;
    exp_q.delete(); push_run(8'h80, 64);
    step();
    jmp = 1'b0; branch = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    check_eq("jb_bub1", {31'd0, id_valid}, 32'd0);
    check_eq("jb_nop", id_instr, 32'h0000_0000);
    step();
    check_eq("jb_bub2", {31'd0, id_valid}, 32'd0);
    step();
    check_eq("jb_valid", {31'd0, id_valid}, 32'd1);
    check_eq("jb_instr", id_instr, 32'h1000_0080);

    // Jump to 0xFE and wrap
    jmp = 1'b1; pc_jmp = 8'hFE;
    exp_q.delete(); push_run(8'hFE, 64);
    step();
    jmp = 1'b0;
    check_eq("wr_addr_fe", {24'd0, imem_addr}, 32'hFE);
    step();
    check_eq("wr_addr_ff", {24'd0, imem_addr}, 32'hFF);
    step();
    check_eq("wr_addr_00", {24'd0, imem_addr}, 32'h00);
    check_eq("wr_instr_fe", id_instr, 32'h1000_00FE);
    step();
    check_eq("wr_instr_ff", id_instr, 32'h1000_00FF);
    check_eq("wr_pc_ff", {24'd0, id_pc}, 32'h00);

    // Async reset mid-HOLD
    stall = 1'b1;
    step(); step();
    check_eq("hold_valid", {31'd0, id_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", {31'd0, id_valid}, 32'd0);
    check_eq("ar_instr", id_instr, 32'h0000_0000);
    check_eq("ar_en", {31'd0, imem_en}, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); push_run(8'h00, 64);
    #1;
    check_eq("ar_rel_addr", {24'd0, imem_addr}, 32'h00);
    step(); step();
    check_eq("ar_instr0", id_instr, 32'h1000_0000);
    check_eq("ar_pc0", {24'd0, id_pc}, 32'h01);
    step(); step();
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetched", {16'd0, perf_fetched}, pops);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
